// File: rtl/kyber_enc_pkg.sv
// Shared types and constants for the PKE encryption poly sequencer.
// State encoding plus the Kyber ring dimensions the sequencer walks.
package kyber_enc_pkg;

  localparam int KYBER_N_PAIRS = 128;
  localparam int K_MAX         = 4;
  localparam int NONCE_W       = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HASH_REQ,
    S_HASH_WAIT,
    S_LOAD,
    S_NTT_REQ,
    S_NTT_WAIT,
    S_DRAIN,
    S_NEXT,
    S_FIN
  } seq_state_t;

endpackage

// File: rtl/kyber_idx_counter.sv
// Coefficient-pair index counter with enable, clear and terminal count.
// Wraps to zero on the terminal transfer so load and drain can share it.
module kyber_idx_counter #(
  parameter int W   = 8,
  parameter int MAX = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kyber_enc_poly_seq.sv
// Per-polynomial sequencer: hash request, pair load, optional NTT, drain.
// Generates nonce, pair and poly indices for the encryption datapath.
module kyber_enc_poly_seq
  import kyber_enc_pkg::*;
#(
  parameter int K       = K_MAX,
  parameter int N_PAIRS = KYBER_N_PAIRS,
  parameter int IDX_W   = 8,
  parameter int KW      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic               start,
  input  logic [KW-1:0]      k_sel,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [K-1:0]       bypass_mask,
  output logic               hash_start,
  output logic [NONCE_W-1:0] hash_nonce,
  input  logic               hash_done,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [IDX_W-1:0]   load_index,
  output logic               ntt_start,
  input  logic               ntt_done,
  output logic               dst_valid,
  input  logic               dst_ready,
  output logic [IDX_W-1:0]   dst_index,
  output logic [KW-1:0]      dst_k,
  output logic               busy,
  output logic               done,
  output logic               err
);

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [KW-1:0]      r_k;
  logic [KW-1:0]      r_poly;
  logic [NONCE_W-1:0] r_base;
  logic [K-1:0]       r_mask;
  logic               r_err;
  logic [IDX_W-1:0]   w_pair;
  logic               w_tc;
  logic               w_kok;
  logic               w_byp;
  logic [K-1:0]       w_msh;
  logic               w_load_fire;
  logic               w_drain_fire;
  logic               w_launch;

  assign w_kok  = (k_sel != '0) && (k_sel <= KW'(K));
  assign w_msh  = r_mask >> r_poly;
  assign w_byp  = w_msh[0];
  assign w_launch = set && (r_state == S_IDLE) && start;

  // All handshake/pulse outputs are gated by set so nothing fires while frozen.
  assign busy       = (r_state != S_IDLE);
  assign hash_start = set && (r_state == S_HASH_REQ);
  assign ntt_start  = set && (r_state == S_NTT_REQ);
  assign done       = set && (r_state == S_FIN);
  assign src_ready  = set && (r_state == S_LOAD);
  assign dst_valid  = set && (r_state == S_DRAIN);
  assign load_index = (r_state == S_LOAD)  ? w_pair : '0;
  assign dst_index  = (r_state == S_DRAIN) ? w_pair : '0;
  assign dst_k      = (r_state == S_DRAIN) ? r_poly : '0;
  assign hash_nonce = r_base + NONCE_W'(r_poly);
  assign err        = r_err;

  assign w_load_fire  = src_ready && src_valid;
  assign w_drain_fire = dst_valid && dst_ready;

  kyber_idx_counter #(
    .W   (IDX_W),
    .MAX (N_PAIRS)
  ) u_pair (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_load_fire || w_drain_fire),
    .i_clr (w_launch),
    .o_cnt (w_pair),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (start && w_kok) w_next = S_HASH_REQ;
      S_HASH_REQ:  w_next = S_HASH_WAIT;
      S_HASH_WAIT: if (hash_done) w_next = S_LOAD;
      S_LOAD:
        if (src_valid && w_tc)
          w_next = w_byp ? S_DRAIN : S_NTT_REQ;
      S_NTT_REQ:   w_next = S_NTT_WAIT;
      S_NTT_WAIT:  if (ntt_done) w_next = S_DRAIN;
      S_DRAIN:     if (dst_ready && w_tc) w_next = S_NEXT;
      S_NEXT:
        w_next = (r_poly == r_k - 1'b1) ? S_FIN : S_HASH_REQ;
      S_FIN:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (set) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k    <= '0;
      r_poly <= '0;
      r_base <= '0;
      r_mask <= '0;
      r_err  <= 1'b0;
    end else if (set) begin
      if (r_state == S_IDLE && start) begin
        if (w_kok) begin
          r_k    <= k_sel;
          r_base <= nonce_base;
          r_mask <= bypass_mask;
          r_poly <= '0;
        end else begin
          r_err  <= 1'b1;
        end
      end else if (r_state == S_NEXT) begin
        r_poly <= r_poly + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kyber_enc_poly_seq.sv
// Directed bench for kyber_enc_poly_seq: vector table of runs plus
// hand sequences for error handling and mid-run reset.
module tb_kyber_enc_poly_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       set;
  logic       start;
  logic [2:0] k_sel;
  logic [7:0] nonce_base;
  logic [3:0] bypass_mask;
  logic       hash_start;
  logic [7:0] hash_nonce;
  logic       hash_done;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] load_index;
  logic       ntt_start;
  logic       ntt_done;
  logic       dst_valid;
  logic       dst_ready;
  logic [7:0] dst_index;
  logic [2:0] dst_k;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] k;
    logic [7:0] base;
    logic [3:0] mask;
    bit         stall;
    bit         sgap;
    int         exp_ntt;
    logic [7:0] exp_last_nonce;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  kyber_enc_poly_seq dut (
    .clk         (clk),
    .reset       (reset),
    .set         (set),
    .start       (start),
    .k_sel       (k_sel),
    .nonce_base  (nonce_base),
    .bypass_mask (bypass_mask),
    .hash_start  (hash_start),
    .hash_nonce  (hash_nonce),
    .hash_done   (hash_done),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .load_index  (load_index),
    .ntt_start   (ntt_start),
    .ntt_done    (ntt_done),
    .dst_valid   (dst_valid),
    .dst_ready   (dst_ready),
    .dst_index   (dst_index),
    .dst_k       (dst_k),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {hash_start, hash_nonce, src_ready, load_index, ntt_start,
            dst_valid, dst_index, dst_k, busy, done, err};
  endfunction

  // One run; abort>=0 asserts reset while draining poly 1 at that index.
  task automatic run(input vec_t v, input int abort, input bit exp_err);
    int hcnt, ncnt, nh, nn, nl, nd, nx, el, ed, ep;
    logic [7:0] last_nonce;
    bit fin;
    hcnt = 0; ncnt = 0; nh = 0; nn = 0; nl = 0; nd = 0; nx = 0;
    el = 0; ed = 0; ep = 0; fin = 0; last_nonce = 8'h00;
    hash_done = 0; ntt_done = 0;
    @(negedge clk);
    set = 1; start = 1;
    k_sel = v.k; nonce_base = v.base; bypass_mask = v.mask;
    @(negedge clk);
    // Scramble config inputs; start while busy must be ignored.
    k_sel = 3'd0; nonce_base = 8'h5A; bypass_mask = 4'hF;
    start = v.stall;
    for (int cyc = 0; cyc < 12000 && !fin; cyc++) begin
      set = v.sgap ? ($urandom_range(0, 4) != 0) : 1'b1;
      src_valid = v.stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      dst_ready = v.stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (hcnt > 0) begin hcnt--; if (hcnt == 0) hash_done = 1; end
      if (ncnt > 0) begin ncnt--; if (ncnt == 0) ntt_done = 1; end
      #1;
      if (hash_start) begin
        chk("hash_nonce", hash_nonce, 8'(v.base + 8'(nh)));
        last_nonce = hash_nonce;
        nh++; hcnt = 2; hash_done = 0;
      end
      if (ntt_start) begin
        nn++; ncnt = 3; ntt_done = 0;
      end
      if (src_ready && src_valid) begin
        chk("load_index", load_index, el);
        el = (el + 1) % 128; nl++;
      end
      if (dst_valid) begin
        chk("dst_index", dst_index, ed);
        chk("dst_k", dst_k, ep);
        if (abort >= 0 && dst_k == 3'd1 && dst_index == 8'(abort)) begin
          reset = 0;
          #1;
          chk("abort_outs_zero", all_outs(), 32'h0);
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
          end
          chk("abort_done_count", nx, 0);
          reset = 1; start = 0;
          return;
        end
        if (dst_ready) begin
          nd++; ed++;
          if (ed == 128) begin ed = 0; ep++; end
        end
      end
      if (done) begin nx++; fin = 1; end
      @(negedge clk);
    end
    start = 0; set = 1;
    if (!fin) begin
      errors++;
      $display("FAIL run_timeout: got no done expected done");
    end
    #1;
    chk("hash_count", nh, v.k);
    chk("last_nonce", last_nonce, v.exp_last_nonce);
    chk("ntt_count", nn, v.exp_ntt);
    chk("load_count", nl, 32'(v.k) * 128);
    chk("drain_count", nd, 32'(v.k) * 128);
    chk("done_count", nx, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("err_after", err, exp_err);
  endtask

  initial begin
    vecs[0] = '{3'd3, 8'h10, 4'b0000, 1'b0, 1'b0, 3, 8'h12};
    vecs[1] = '{3'd2, 8'h20, 4'b0010, 1'b0, 1'b0, 1, 8'h21};
    vecs[2] = '{3'd4, 8'h30, 4'b0000, 1'b1, 1'b0, 4, 8'h33};
    vecs[3] = '{3'd2, 8'hFF, 4'b0000, 1'b0, 1'b0, 2, 8'h00};
    vecs[4] = '{3'd4, 8'h40, 4'b0101, 1'b1, 1'b1, 2, 8'h43};
    vecs[5] = '{3'd1, 8'h07, 4'b0001, 1'b0, 1'b0, 0, 8'h07};

    reset = 0; set = 0; start = 0; k_sel = 0; nonce_base = 0;
    bypass_mask = 0; hash_done = 0; ntt_done = 0;
    src_valid = 0; dst_ready = 0;
    #12;
    chk("reset_outs", all_outs(), 32'h0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    chk("idle_outs", all_outs(), 32'h0);

    for (int i = 0; i < 6; i++) run(vecs[i], -1, 1'b0);

    // k_sel above K
    @(negedge clk);
    set = 1; start = 1; k_sel = 3'd5;
    @(negedge clk);
    start = 0; #1;
    chk("err_k5", err, 1);
    chk("busy_k5", busy, 0);
    // k_sel zero, after clearing err by reset
    reset = 0; #1; reset = 1;
    chk("err_cleared", err, 0);
    @(negedge clk);
    start = 1; k_sel = 3'd0;
    @(negedge clk);
    start = 0; #1;
    chk("err_k0", err, 1);
    chk("busy_k0", busy, 0);
    @(negedge clk);
    #1;
    chk("busy_k0_hold", busy, 0);
    run(vecs[0], -1, 1'b1);

    run(vecs[1], 5, 1'b0);
    @(negedge clk);
    #1;
    chk("post_abort_busy", busy, 0);
    run(vecs[0], -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kyber_enc_poly_seq.md
Name: kyber_enc_poly_seq

Overview:
- Parametrised per-polynomial sequencer for the PKE encryption datapath; successor to the hard-wired hash/cbd/ntt/polyvec FSM chain.
- Drives a run of 1..K polynomials through four stages: hash request, coefficient-pair load, optional NTT, drain to accumulator.
- Per-polynomial NTT bypass (for e1/e2 noise), programmable nonce base, and back-pressure on both load and drain. The fixed-count chain it replaces had none of these.
- Sits between the input FSM and the hash_stub / cbd / ntt / polyvec instances; generates all indices and counters they consume.

Parameters:
- K, 4, maximum polynomials per run (2..4).
- N_PAIRS, 128, coefficient pairs per polynomial.
- IDX_W, 8, pair-index width; must satisfy 2^IDX_W >= N_PAIRS.
- KW, 3, width of poly count / poly index.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset), same name as elsewhere in the codebase
- set  in  1  global enable; state holds when 0
- start  in  1  begin a run (sampled only in IDLE)
- k_sel  in  KW  polys this run, 1..K
- nonce_base  in  8  nonce of poly 0
- bypass_mask  in  K  bit i=1: poly i skips NTT
- hash_start  out  1  one-cycle pulse, request hash of current poly
- hash_nonce  out  8  nonce_base + poly index, stable while poly active
- hash_done  in  1  hash output ready
- src_valid  in  1  CBD pair valid
- src_ready  out  1  sequencer accepts pair
- load_index  out  IDX_W  pair index being written, 0..N_PAIRS-1
- ntt_start  out  1  one-cycle pulse (ntt cal_en)
- ntt_done  in  1  NTT finished
- dst_valid  out  1  drain pair valid
- dst_ready  in  1  accumulator accepts pair
- dst_index  out  IDX_W  drain pair index
- dst_k  out  KW  current poly index
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run end
- err  out  1  sticky: start with k_sel==0 or k_sel>K; cleared by reset only

Behaviour:
- Reset (async, reset==0): state=IDLE; all outputs 0; counters 0; err=0.
- set==0: no state, counter or pulse update; pulses do not re-fire when set returns.
- States: IDLE, HASH_REQ, HASH_WAIT, LOAD, NTT_REQ, NTT_WAIT, DRAIN, NEXT, FIN.
- IDLE:
  - start & valid k_sel: latch k_sel, nonce_base, bypass_mask; poly=0; go to HASH_REQ.
  - start & invalid k_sel: set err, stay IDLE.
- HASH_REQ: hash_start=1 for exactly one cycle, then HASH_WAIT. Latency start->hash_start is 1 cycle.
- HASH_WAIT: on hash_done go to LOAD with pair=0.
- LOAD:
  - src_ready=1; load_index=pair.
  - Each src_valid&src_ready cycle: pair++.
  - On the transfer with pair==N_PAIRS-1: pair=0; go to NTT_REQ, or to DRAIN if bypass_mask[poly].
- NTT_REQ: ntt_start one cycle, then NTT_WAIT. NTT_WAIT: on ntt_done go to DRAIN.
- DRAIN:
  - dst_valid=1; dst_index=pair; dst_k=poly.
  - pair++ on dst_valid&dst_ready. Outputs hold while dst_ready=0.
  - Last transfer (pair==N_PAIRS-1) goes to NEXT.
- NEXT: poly++; if poly==k_sel-1 (pre-increment) go to FIN, else HASH_REQ.
- FIN: done=1 one cycle, then IDLE.
- hash_nonce = (nonce_base + poly) mod 256, 8-bit wrap (base 255, poly 1 -> 0).
- Stray inputs: hash_done, ntt_done or src_valid outside their wait/load states are ignored. start while busy is ignored (no err).
- Same-cycle hash_done & ntt_done: only the one matching the current state acts.
- Reset mid-run aborts immediately: no done pulse, outputs 0.

Decomposition:
- Package kyber_enc_pkg: state enum, KYBER_N_PAIRS=128, K_MAX=4, nonce width 8.
- Natural sub-module: kyber_idx_counter. It is a pair counter with enable, clear and terminal-count flag, and is reused for load and drain.

Test Plan:
- k_sel=3, nonce_base=0x10, mask=0, no stalls.
  - hash_nonce=0x10, 0x11, 0x12.
  - 3 ntt_start pulses; 3x128 load and 3x128 drain transfers with indices 0..127.
  - dst_k=0,1,2; single done.
- k_sel=2, mask=2'b10: exactly one ntt_start (poly 0); poly 1 goes from LOAD straight to DRAIN.
- Random src_valid/dst_ready gaps (~30%): no index skipped or duplicated; dst_index holds during dst_ready=0.
- nonce_base=0xFF, k_sel=2: hash_nonce 0xFF then 0x00.
- start with k_sel=0, then k_sel=5 (K=4): err=1, busy stays 0; a later valid start still runs and err stays 1.
- reset=0 in DRAIN of poly 1: all outputs 0 asynchronously, no done. A fresh run then starts at poly 0 with pair 0.
